// File: rtl/sym_gen_pkg.sv
// Shared constants for the symbol generator: symbol table, LFSR defaults, FIFO entry layout.
package sym_gen_pkg;
  localparam int SYM_W_DEF       = 8;
  localparam int TABLE_DEPTH_DEF = 16;
  localparam int IDX_W_DEF       = $clog2(TABLE_DEPTH_DEF);

  localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;
  localparam logic [15:0] SEED_DEF      = 16'hACE1;

  localparam logic [SYM_W_DEF-1:0] SYM_TABLE [0:TABLE_DEPTH_DEF-1] = '{
    8'hEA, 8'hF1, 8'hD6, 8'h89, 8'h9E, 8'hE5, 8'hB6, 8'hBF,
    8'hDA, 8'hD5, 8'hE6, 8'h9D, 8'hF8, 8'hB3, 8'hF4, 8'hED
  };

  typedef struct packed {
    logic                 special;
    logic [IDX_W_DEF-1:0] idx;
    logic [SYM_W_DEF-1:0] sym;
  } sym_entry_t;
endpackage

// File: rtl/sym_fifo.sv
// Small synchronous FIFO with synchronous flush; head is zero while empty.
module sym_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         Clk100M,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][W-1:0]    mem_q, mem_d;
  logic                       do_pop;

  // Extra pointer bit distinguishes full from empty when the slot bits match.
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop && !empty;
  assign dout   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + (AW+1)'(1);
      end
      if (do_pop) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/sym_gen_multi.sv
// Game-symbol generator: rate divider, Galois LFSR, index select and drop counter,
// feeding a small output FIFO behind a valid/ready handshake.
module sym_gen_multi import sym_gen_pkg::*; #(
  parameter int                SYM_W        = SYM_W_DEF,
  parameter int                TABLE_DEPTH  = TABLE_DEPTH_DEF,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = LFSR_TAPS_DEF,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEF,
  parameter int                RATE_W       = 32,
  parameter int                FIFO_DEPTH   = 4,
  localparam int               IDX_W        = $clog2(TABLE_DEPTH)
) (
  input  logic              Clk100M,
  input  logic              rst_n,
  input  logic              en,
  input  logic [RATE_W-1:0] rate_max,
  input  logic              mode,
  input  logic              no_repeat,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [IDX_W-1:0]  target_idx,
  input  logic              flush,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic [IDX_W-1:0]  sym_idx,
  output logic              sym_special,
  output logic [15:0]       drop_count
);
  localparam int ENT_W = 1 + IDX_W + SYM_W;

  logic [RATE_W-1:0] cnt_q, cnt_d, eff_max;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d, idx_sel;
  logic [15:0]       drop_q, drop_d;
  logic              tick, full, empty, push, pop;
  logic [ENT_W-1:0]  push_ent, head_ent;

  always_comb begin
    eff_max = (rate_max == '0) ? RATE_W'(1) : rate_max;
    // Comparing with >= lets a lowered rate_max fire on the very next cycle.
    tick    = en && (cnt_q >= eff_max - RATE_W'(1));
    cnt_d   = (!en || tick) ? '0 : cnt_q + RATE_W'(1);

    if (seed_load)      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    else if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
    else                lfsr_d = lfsr_q >> 1;

    if (mode) begin
      idx_sel = last_idx_q + IDX_W'(1);
    end else begin
      idx_sel = lfsr_q[IDX_W-1:0];
      if (no_repeat && idx_sel == last_idx_q) idx_sel = idx_sel + IDX_W'(1);
    end
    last_idx_d = tick ? idx_sel : last_idx_q;
    push_ent   = {idx_sel == target_idx, idx_sel, SYM_W'(SYM_TABLE[idx_sel])};

    // A full FIFO still accepts a tick when the head leaves in the same cycle.
    pop    = !empty && sym_ready;
    push   = tick && !flush && (!full || pop);
    drop_d = drop_q;
    if (tick && !flush && full && !pop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      lfsr_q     <= SEED_DEFAULT;
      last_idx_q <= IDX_W'(TABLE_DEPTH - 1);
      drop_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      last_idx_q <= last_idx_d;
      drop_q     <= drop_d;
    end
  end

  sym_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk100M (Clk100M),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .din     (push_ent),
    .pop     (pop),
    .dout    (head_ent),
    .full    (full),
    .empty   (empty)
  );

  assign sym_valid                         = !empty;
  assign {sym_special, sym_idx, sym_data}  = head_ent;
  assign drop_count                        = drop_q;
endmodule

// File: tb/tb_sym_gen_multi.sv
// Bench for sym_gen_multi: queue-based behavioural model checked every cycle, plus directed literals.
module tb_sym_gen_multi;
  import sym_gen_pkg::*;

  logic        Clk100M = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, mode = 1'b1, no_repeat = 1'b0, seed_load = 1'b0, flush = 1'b0;
  logic        sym_ready = 1'b1;
  logic [31:0] rate_max = 32'd3;
  logic [15:0] seed = 16'h0;
  logic [3:0]  target_idx = 4'd5;
  logic        sym_valid, sym_special;
  logic [7:0]  sym_data;
  logic [3:0]  sym_idx;
  logic [15:0] drop_count;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  sym_gen_multi dut (
    .Clk100M(Clk100M), .rst_n(rst_n), .en(en), .rate_max(rate_max), .mode(mode),
    .no_repeat(no_repeat), .seed_load(seed_load), .seed(seed), .target_idx(target_idx),
    .flush(flush), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .sym_idx(sym_idx), .sym_special(sym_special), .drop_count(drop_count)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk100M);
    #1;
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Behavioural model: FIFO as a queue, rate as enabled cycles since last symbol.
  sym_entry_t  mq[$];
  int          m_cnt, m_last, m_drop, m_ix, m_eff;
  logic [15:0] m_lfsr;
  bit          m_tick, m_pop;

  initial forever begin
    @(posedge Clk100M or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0; m_last = 15; m_drop = 0; m_lfsr = 16'hACE1;
    end else begin
      m_eff  = (rate_max == 0) ? 1 : int'(rate_max);
      m_pop  = (mq.size() > 0) && sym_ready;
      m_tick = 1'b0;
      if (!en) m_cnt = 0;
      else if (m_cnt >= m_eff - 1) begin m_tick = 1'b1; m_cnt = 0; end
      else m_cnt++;
      if (mode) m_ix = (m_last + 1) % 16;
      else begin
        m_ix = int'(m_lfsr & 16'hF);
        if (no_repeat && m_ix == m_last) m_ix = (m_ix + 1) % 16;
      end
      if (flush) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_tick) begin
          if (mq.size() < 4) mq.push_back(sym_entry_t'{(m_ix == int'(target_idx)), 4'(m_ix), SYM_TABLE[m_ix]});
          else if (m_drop < 65535) m_drop++;
        end
      end
      if (m_tick) m_last = m_ix;
      m_lfsr = seed_load ? ((seed == 0) ? 16'h1 : seed) : lstep(m_lfsr);
    end
  end

  // Per-cycle compare and a log of every accepted head for directed checks.
  sym_entry_t log_q[$];
  initial forever begin
    @(negedge Clk100M);
    if (rst_n === 1'b1 && chk_en) begin
      chk("valid", sym_valid, mq.size() > 0);
      if (mq.size() > 0) chk("head", {sym_special, sym_idx, sym_data}, mq[0]);
      chk("drop", drop_count, m_drop);
    end
    if (rst_n === 1'b1 && sym_valid === 1'b1 && sym_ready === 1'b1)
      log_q.push_back({sym_special, sym_idx, sym_data});
  end

  int gaps, viol;
  int run_a[20], run_b[20];

  initial begin
    #2 rst_n = 1'b0;
    cyc(2);
    chk("rst_valid", sym_valid, 0);
    chk("rst_head", {sym_special, sym_idx, sym_data}, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Sequential mode, one symbol every 3 cycles, with idx 5 as target.
    log_q.delete();
    en = 1'b1;
    cyc(3 * 18 + 2);
    en = 1'b0;
    cyc(3);
    chk("t1_count", log_q.size(), 18);
    for (int i = 0; i < 18 && i < log_q.size(); i++) begin
      chk("t1_idx", log_q[i].idx, i % 16);
      chk("t1_special", log_q[i].special, (i % 16) == 5);
    end
    if (log_q.size() >= 17) begin
      chk("t1_sym0", log_q[0].sym, 8'hEA);
      chk("t1_sym5", log_q[5].sym, 8'hE5);
      chk("t1_sym15", log_q[15].sym, 8'hED);
      chk("t1_wrap", log_q[16].sym, 8'hEA);
    end

    // rate_max 0 and 1 both give one symbol per cycle.
    for (int r = 0; r < 2; r++) begin
      rate_max = r;
      en = 1'b1;
      cyc(2);
      gaps = 0;
      for (int i = 0; i < 20; i++) begin
        if (sym_valid !== 1'b1) gaps++;
        cyc(1);
      end
      chk("t2_gaps", gaps, 0);
      en = 1'b0;
      cyc(3);
    end

    // Full FIFO with consumer stalled: 4 held, 6 dropped, head frozen.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    mode = 1'b1; rate_max = 32'd1; sym_ready = 1'b0; en = 1'b1;
    cyc(10);
    en = 1'b0;
    cyc(1);
    chk("t4_drop", drop_count, 6);
    chk("t4_head_idx", sym_idx, 0);
    chk("t4_head_sym", sym_data, 8'hEA);
    en = 1'b1; sym_ready = 1'b1;
    cyc(1);
    en = 1'b0; sym_ready = 1'b0;
    cyc(1);
    chk("t4_popfull_drop", drop_count, 6);
    chk("t4_popfull_head", sym_idx, 1);
    en = 1'b1; flush = 1'b1;
    cyc(1);
    en = 1'b0; flush = 1'b0;
    cyc(1);
    chk("flush_valid", sym_valid, 0);
    chk("flush_drop", drop_count, 6);

    // Asynchronous reset with the FIFO half full.
    en = 1'b1;
    cyc(2);
    en = 1'b0;
    chk("t6_prefill", sym_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", sym_valid, 0);
    chk("t6_drop", drop_count, 0);
    cyc(1);
    rst_n = 1'b1;
    log_q.delete();
    sym_ready = 1'b1; en = 1'b1;
    cyc(3);
    en = 1'b0;
    cyc(3);
    chk("t6_count", log_q.size(), 3);
    if (log_q.size() > 0) chk("t6_first_idx", log_q[0].idx, 0);

    // Random mode: zero seed loads 1 -> indices 1,0,0,0.
    mode = 1'b0; seed = 16'h0; seed_load = 1'b1;
    cyc(1);
    seed_load = 1'b0;
    log_q.delete();
    en = 1'b1;
    cyc(4);
    en = 1'b0;
    cyc(3);
    chk("t3_zero_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("t3_zero_idx", log_q[i].idx, (i == 0) ? 1 : 0);

    // Same seed twice gives the same stream.
    for (int r = 0; r < 2; r++) begin
      seed = 16'h1234; seed_load = 1'b1;
      cyc(1);
      seed_load = 1'b0;
      log_q.delete();
      en = 1'b1;
      cyc(20);
      en = 1'b0;
      cyc(3);
      chk("t3_seed_count", log_q.size(), 20);
      for (int i = 0; i < 20; i++) begin
        if (r == 0) run_a[i] = (i < log_q.size()) ? int'(log_q[i].idx) : -1;
        else        run_b[i] = (i < log_q.size()) ? int'(log_q[i].idx) : -1;
      end
    end
    chk("t3_seed_first", run_a[0], 4);
    chk("t3_seed_second", run_a[1], 10);
    for (int i = 0; i < 20; i++) chk("t3_repro", run_b[i], run_a[i]);

    // no_repeat over 10k symbols.
    no_repeat = 1'b1;
    log_q.delete();
    en = 1'b1;
    cyc(10000);
    en = 1'b0;
    cyc(3);
    viol = 0;
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i].idx == log_q[i-1].idx) viol++;
    chk("t3_nr_count", log_q.size(), 10000);
    chk("t3_nr_repeats", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
